// File: rtl/lpcm_scoreboard.sv
// In-order scoreboard for the LPCM monitor stream: expected items queue in a FIFO and each
// collected item is compared against the head, with a drain phase and a final pass verdict.
module lpcm_scoreboard #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned DRAIN_CYCLES = 1000,
  parameter int unsigned CNT_W        = 16,
  // Width of a packed lpcm_pkg::lpcm_item.
  parameter int unsigned ITEM_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exp_en,
  input  logic [ITEM_W-1:0] exp_item,
  input  logic              item_collected_en,
  input  logic [ITEM_W-1:0] item_collected,
  input  logic              agent_done,
  output logic              err_en,
  output logic [ITEM_W-1:0] err_exp,
  output logic [ITEM_W-1:0] err_act,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic              overflow,
  output logic              done,
  output logic              pass
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OW = AW + 1;
  localparam int unsigned TW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam int unsigned SW = ((CNT_W > OW) ? CNT_W : OW) + 2;

  localparam logic [OW-1:0] DepthCnt  = OW'(DEPTH);
  localparam logic [TW-1:0] TimerLast = TW'(DRAIN_CYCLES - 1);
  localparam logic [SW-1:0] CntMaxExt = SW'({CNT_W{1'b1}});

  typedef enum logic [1:0] {StRun, StDrain, StFinished} state_e;

  logic [ITEM_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [OW-1:0]     count_q, count_d;
  logic [TW-1:0]     timer_q, timer_d;
  state_e            state_q, state_d;

  logic              err_en_q;
  logic [ITEM_W-1:0] err_exp_q, err_act_q;
  logic [CNT_W-1:0]  match_q, match_d;
  logic [CNT_W-1:0]  mismatch_q, mismatch_d;
  logic              overflow_q;

  logic              empty, full, push, pop, bypass, unexpected, ovf_set;
  logic              cmp_err, cmp_ok, timeout;
  logic [ITEM_W-1:0] ref_item;
  logic [SW-1:0]     mismatch_sum;

  assign empty      = (count_q == '0);
  assign full       = (count_q == DepthCnt);
  assign pop        = item_collected_en && !empty;
  assign bypass     = item_collected_en && empty && exp_en;
  assign unexpected = item_collected_en && empty && !exp_en;
  // A full FIFO that pops this cycle frees the slot the push needs.
  assign push       = exp_en && !bypass && (!full || pop);
  assign ovf_set    = exp_en && full && !pop;
  assign count_d    = count_q + OW'(push) - OW'(pop);

  always_comb begin
    ref_item = '0;
    if (!empty) begin
      ref_item = mem[rd_ptr_q];
    end else if (bypass) begin
      ref_item = exp_item;
    end
  end

  assign cmp_err = item_collected_en && (unexpected || (ref_item != item_collected));
  assign cmp_ok  = item_collected_en && !cmp_err;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    timeout = 1'b0;
    unique case (state_q)
      StRun: begin
        timer_d = '0;
        if (agent_done) begin
          state_d = empty ? StFinished : StDrain;
        end
      end
      StDrain: begin
        if (timer_q == TimerLast) begin
          timeout = 1'b1;
          state_d = StFinished;
        end else if (count_d == '0) begin
          state_d = StFinished;
        end
        timer_d = item_collected_en ? '0 : timer_q + TW'(1);
      end
      StFinished: begin
        timer_d = '0;
      end
      default: begin
        state_d = StRun;
        timer_d = '0;
      end
    endcase
  end

  // Items still queued at drain timeout are charged as mismatches.
  always_comb begin
    mismatch_sum = SW'(mismatch_q) + SW'(cmp_err) + (timeout ? SW'(count_d) : '0);
    mismatch_d   = (mismatch_sum > CntMaxExt) ? {CNT_W{1'b1}} : mismatch_sum[CNT_W-1:0];
    match_d      = (cmp_ok && (match_q != {CNT_W{1'b1}})) ? match_q + CNT_W'(1) : match_q;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= exp_item;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      timer_q    <= '0;
      state_q    <= StRun;
      err_en_q   <= 1'b0;
      err_exp_q  <= '0;
      err_act_q  <= '0;
      match_q    <= '0;
      mismatch_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q    <= count_d;
      timer_q    <= timer_d;
      state_q    <= state_d;
      err_en_q   <= cmp_err;
      if (cmp_err) begin
        err_exp_q <= ref_item;
        err_act_q <= item_collected;
      end
      match_q    <= match_d;
      mismatch_q <= mismatch_d;
      overflow_q <= overflow_q | ovf_set;
    end
  end

  assign err_en       = err_en_q;
  assign err_exp      = err_exp_q;
  assign err_act      = err_act_q;
  assign match_cnt    = match_q;
  assign mismatch_cnt = mismatch_q;
  assign overflow     = overflow_q;
  assign done         = (state_q == StFinished);
  assign pass         = done && (mismatch_q == '0) && !overflow_q && (match_q != '0);

endmodule
